// File: rtl/nexys_starship_game_ctrl_if.sv
// Nexys Starship game controller bundle.
// Board-side buttons and loss flag in; state and counters out.
interface nexys_starship_game_ctrl_if #(
  parameter int TIMER_W = 16,
  parameter int LEVEL_W = 2
);
  logic               BtnU;
  logic               BtnC;
  logic               game_over;
  logic               q_Init;
  logic               q_Play;
  logic               q_Pause;
  logic               q_GameOver;
  logic               play_flag;
  logic [TIMER_W-1:0] game_secs;
  logic [LEVEL_W-1:0] level;
  logic               level_up;

  modport master (
    output BtnU, BtnC, game_over,
    input  q_Init, q_Play, q_Pause, q_GameOver,
    input  play_flag, game_secs, level, level_up
  );

  modport slave (
    input  BtnU, BtnC, game_over,
    output q_Init, q_Play, q_Pause, q_GameOver,
    output play_flag, game_secs, level, level_up
  );
endinterface

// File: rtl/nexys_starship_game_ctrl.sv
// Nexys Starship game FSM with seconds timer and difficulty levels.
// Define NEXYS_STARSHIP_PAUSE_EN to build in the PAUSE state on BtnC.
module nexys_starship_game_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int TIMER_W       = 16,
  parameter int LEVEL_W       = 2,
  parameter int NUM_LEVELS    = 4,
  parameter int LEVEL_SECS    = 30
) (
  input logic Clk,
  input logic Reset,
  nexys_starship_game_ctrl_if.slave bus
);

  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam int SW = (LEVEL_SECS > 1) ? $clog2(LEVEL_SECS) : 1;

  localparam logic [TW-1:0]      TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0]      SEC_LAST  = SW'(LEVEL_SECS - 1);
  localparam logic [LEVEL_W-1:0] LVL_LAST  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [TIMER_W-1:0] SECS_MAX  = '1;

  typedef enum logic [3:0] {
    INIT     = 4'b0001,
    PLAY     = 4'b0010,
    PAUSE    = 4'b0100,
    GAMEOVER = 4'b1000
  } state_t;

  state_t             state;
  logic [TW-1:0]      tick_cnt;
  logic [SW-1:0]      sec_in_level;
  logic [TIMER_W-1:0] secs;
  logic [LEVEL_W-1:0] lvl;
  logic               play;
  logic               lvl_up;
  logic               btnU_prev;
  logic               u_rise;

  assign u_rise = bus.BtnU & ~btnU_prev;

`ifdef NEXYS_STARSHIP_PAUSE_EN
  logic btnC_prev;
  logic c_rise;

  assign c_rise = bus.BtnC & ~btnC_prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) btnC_prev <= 1'b0;
    else       btnC_prev <= bus.BtnC;
  end
`else
  logic unused_btnc;

  assign unused_btnc = bus.BtnC;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= INIT;
      tick_cnt     <= '0;
      sec_in_level <= '0;
      secs         <= '0;
      lvl          <= '0;
      play         <= 1'b0;
      lvl_up       <= 1'b0;
      btnU_prev    <= 1'b0;
    end else begin
      btnU_prev <= bus.BtnU;
      lvl_up    <= 1'b0;
      case (state)
        INIT: begin
          if (u_rise) begin
            state        <= PLAY;
            play         <= 1'b1;
            tick_cnt     <= '0;
            sec_in_level <= '0;
            secs         <= '0;
            lvl          <= '0;
          end
        end
        PLAY: begin
          if (bus.game_over) begin
            state <= GAMEOVER;
            play  <= 1'b0;
          end
`ifdef NEXYS_STARSHIP_PAUSE_EN
          else if (c_rise) begin
            state <= PAUSE;
          end
`endif
          else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (secs != SECS_MAX)
              secs <= secs + 1'b1;
            if (sec_in_level == SEC_LAST) begin
              sec_in_level <= '0;
              // pulse only on a real change, not at the top level
              if (lvl != LVL_LAST) begin
                lvl    <= lvl + 1'b1;
                lvl_up <= 1'b1;
              end
            end else begin
              sec_in_level <= sec_in_level + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`ifdef NEXYS_STARSHIP_PAUSE_EN
        PAUSE: begin
          if (c_rise) state <= PLAY;
        end
`endif
        GAMEOVER: begin
          if (u_rise) state <= INIT;
        end
        default: begin
          state <= INIT;
          play  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_Init     = state[0];
  assign bus.q_Play     = state[1];
`ifdef NEXYS_STARSHIP_PAUSE_EN
  assign bus.q_Pause    = state[2];
`else
  assign bus.q_Pause    = 1'b0;
`endif
  assign bus.q_GameOver = state[3];
  assign bus.play_flag  = play;
  assign bus.game_secs  = secs;
  assign bus.level      = lvl;
  assign bus.level_up   = lvl_up;

endmodule

// File: doc/nexys_starship_game_ctrl.md
# nexys_starship_game_ctrl

Parametrised top-level game controller for Nexys Starship. Successor to the three-state game FSM. Adds:
- button edge detection
- an optional PAUSE state
- a seconds game timer
- a difficulty level counter with a per-level duration

Sits between the debounced board buttons and the display/terminal logic, which read its state and counters.

## Interface

Parameters:
- TICKS_PER_SEC, 100_000_000: Clk cycles per game second; ≥2.
- TIMER_W, 16: width of game_secs.
- LEVEL_W, 2: width of level.
- NUM_LEVELS, 4: number of levels; 1 ≤ NUM_LEVELS ≤ 2**LEVEL_W.
- LEVEL_SECS, 30: game seconds per level; ≥1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  reset; asynchronous, active-high.
- BtnU  in  1  debounced start/restart button, level.
- BtnC  in  1  debounced pause button, level.
- game_over  in  1  loss condition from game logic, level.
- q_Init  out  1  state INIT.
- q_Play  out  1  state PLAY.
- q_Pause  out  1  state PAUSE.
- q_GameOver  out  1  state GAMEOVER.
- play_flag  out  1  session active: state PLAY or PAUSE.
- game_secs  out  TIMER_W  elapsed play seconds.
- level  out  LEVEL_W  current difficulty level, 0-based.
- level_up  out  1  one-cycle pulse on each level increment.

## Operation

- **State register:** one-hot, 4 bits, {GAMEOVER, PAUSE, PLAY, INIT}. The q_* outputs are the state bits directly.
- **Edge detection:** btnU_prev and btnC_prev registers; rise = btn & ~btn_prev. A held button produces exactly one event.
- **INIT:**
  - BtnU rise → PLAY.
  - Clears tick_cnt, game_secs and level on this transition.
  - BtnC and game_over are ignored.
- **PLAY:** transitions, in priority order:
  - game_over=1 → GAMEOVER.
  - Else BtnC rise → PAUSE.
  - Else stay in PLAY and advance counters.
- **Counter advance (PLAY, no transition this cycle):**
  - tick_cnt increments. At TICKS_PER_SEC-1 it wraps to 0 and a second elapses.
  - On a second, game_secs increments, saturating at 2**TIMER_W-1.
  - sec_in_level increments on each second. At LEVEL_SECS-1 it wraps to 0 and a level step occurs.
  - A level step increments level, saturating at NUM_LEVELS-1. level_up pulses only when level actually changes.
- **PAUSE:**
  - BtnC rise → PLAY.
  - All counters are frozen.
  - game_over and BtnU are ignored.
- **GAMEOVER:**
  - Counters are held for score display.
  - BtnU rise → INIT. Counters keep their values until the next INIT→PLAY.
- **Illegal or non-one-hot state:** next cycle → INIT.

## Timing

- **Registered outputs:** all outputs are registered. No combinational path from inputs to outputs.
- **Reset values:**
  - state = INIT, so q_Init=1 and the other q_* = 0.
  - play_flag=0, game_secs=0, level=0, level_up=0.
  - Internal tick_cnt=0, sec_in_level=0, btnU_prev=0, btnC_prev=0.
- **Transition latency:** a button first sampled high at edge k (prev=0) changes state at edge k. q_*/play_flag are visible after edge k.
- **game_over latency:** sampled at edge k in PLAY → q_GameOver=1 after edge k. The counter advance is suppressed in that cycle.
- **Seconds cadence:** the first second elapses TICKS_PER_SEC PLAY cycles after entry. game_secs and level_up update on the same edge as the tick wrap.
- **level_up:** high for exactly one cycle, coincident with the level change.
- **Simultaneous events:**
  - game_over plus BtnC rise in PLAY → GAMEOVER.
  - A second rollover plus a transition out of PLAY → no increment.
- **Reset mid-operation:** immediate asynchronous return to reset values in any state. Buttons held through reset deassertion do not generate an event, because prev updates on the first clock.

## Configuration

- **NEXYS_STARSHIP_PAUSE_EN defined:** PAUSE state and BtnC handling as above.
- **NEXYS_STARSHIP_PAUSE_EN undefined:**
  - PAUSE state, btnC_prev and BtnC logic are compiled out.
  - q_Pause is tied to 0 and BtnC is ignored.
  - PLAY leaves only via game_over.

## Test plan

Parameters for all scenarios: TICKS_PER_SEC=4, TIMER_W=4, LEVEL_W=2, NUM_LEVELS=3, LEVEL_SECS=2.

- **Reset:** Reset pulse → q_Init=1, play_flag=0, game_secs=0, level=0, level_up=0. BtnU held high for 10 cycles → exactly one INIT→PLAY transition, at the first edge.
- **Timer and levels:** BtnU rise, then 24 PLAY cycles → game_secs=6, level=2, level_up pulsed at the end of seconds 2 and 4 only. A further 8 cycles → level stays 2 with no pulse. After 60 cycles total, game_secs saturates at 15.
- **Pause (PAUSE_EN defined):** after 6 PLAY cycles, BtnC rise → q_Pause=1, play_flag=1. 20 cycles in PAUSE → game_secs=1 unchanged. BtnC rise → PLAY; game_secs=2 after 2 more cycles.
- **Game over priority:** game_over and BtnC rise on the same edge in PLAY → q_GameOver=1, game_secs frozen. BtnU rise → INIT with counters held. BtnU rise → PLAY with game_secs=0, level=0.
- **Async reset in PLAY:** Reset asserted mid-cycle at game_secs=3, level=1 → all outputs at reset values before the next Clk edge.
- **PAUSE_EN undefined:** BtnC toggled throughout PLAY → q_Pause always 0, timer unaffected. game_over=1 → GAMEOVER.
